// File: rtl/multisim_server_apb_pull.sv
// APB master that pulls one request at a time from a valid/ready source,
// runs a SETUP/ACCESS transfer, and presents the response (or a timeout) to a consumer.
module multisim_server_apb_pull #(
    parameter type         apb_req_t      = logic [63:0],
    parameter type         apb_resp_t     = logic [31:0],
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_req_valid,
    output logic      o_req_ready,
    input  apb_req_t  i_req,
    output logic      o_resp_valid,
    input  logic      i_resp_ready,
    output apb_resp_t o_resp,
    output logic      o_resp_timeout,
    output apb_req_t  o_apb_m_req,
    input  apb_resp_t i_apb_m_resp,
    output logic      o_apb_m_psel,
    output logic      o_apb_m_penable,
    input  logic      i_apb_m_pready,
    output logic      o_busy
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [32:0] TO_LIMIT = 33'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] cnt_q;
    logic        up_q;
    logic        accept;
    logic        to_hit;

    // up_q keeps the request port closed until the first edge after reset release
    assign accept = (state_q == IDLE) && up_q && i_req_valid;
    assign to_hit = (TIMEOUT_CYCLES != 0) && (({1'b0, cnt_q} + 33'd1) >= TO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            up_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            up_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (i_apb_m_pready || to_hit) state_d = RESP;
            RESP:    if (i_resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready     = (state_q == IDLE) && up_q;
        o_apb_m_psel    = (state_q == SETUP) || (state_q == ACCESS);
        o_apb_m_penable = (state_q == ACCESS);
        o_resp_valid    = (state_q == RESP);
        o_busy          = (state_q != IDLE);
    end

    // Counter saturates so it cannot wrap when the timeout is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_apb_m_req    <= '0;
            o_resp         <= '0;
            o_resp_timeout <= 1'b0;
            cnt_q          <= '0;
        end else begin
            if (accept) begin
                o_apb_m_req <= i_req;
                cnt_q       <= '0;
            end
            if (state_q == ACCESS) begin
                if (i_apb_m_pready) begin
                    o_resp         <= i_apb_m_resp;
                    o_resp_timeout <= 1'b0;
                end else begin
                    if (cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;
                    if (to_hit) begin
                        o_resp         <= '0;
                        o_resp_timeout <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multisim_server_apb_pull.sv
// Bench for multisim_server_apb_pull: transaction-window model checked every cycle,
// plus directed transactions with hand-computed literal expectations.
module tb_multisim_server_apb_pull;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [63:0] i_req = '0;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b1;
    logic [31:0] o_resp;
    logic        o_resp_timeout;
    logic [63:0] o_apb_m_req;
    logic [31:0] i_apb_m_resp;
    logic        o_apb_m_psel;
    logic        o_apb_m_penable;
    logic        i_apb_m_pready = 1'b1;
    logic        o_busy;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wait_cfg = 0;
    logic [31:0] data_cfg = '0;
    int          acc_cnt = 0;

    assign i_apb_m_resp = data_cfg;

    multisim_server_apb_pull #(
        .apb_req_t(logic [63:0]), .apb_resp_t(logic [31:0]), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req(i_req),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp(o_resp), .o_resp_timeout(o_resp_timeout),
        .o_apb_m_req(o_apb_m_req), .i_apb_m_resp(i_apb_m_resp),
        .o_apb_m_psel(o_apb_m_psel), .o_apb_m_penable(o_apb_m_penable),
        .i_apb_m_pready(i_apb_m_pready), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave: pready after wait_cfg ACCESS wait cycles (never if negative), and
    // held high outside ACCESS so the DUT must ignore it there.
    always @(negedge clk) begin
        if (o_apb_m_psel && o_apb_m_penable) begin
            i_apb_m_pready <= (acc_cnt == wait_cfg);
            acc_cnt        <= acc_cnt + 1;
        end else begin
            i_apb_m_pready <= 1'b1;
            acc_cnt        <= 0;
        end
    end

    // Model: each transaction is an accept cycle n plus an access length len;
    // psel covers n+1..n+1+len, penable n+2..n+1+len, response from n+2+len until handshake.
    logic        m_active, m_up, m_to;
    int          m_n, m_len;
    logic [63:0] m_req;
    logic [31:0] m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_up     <= 1'b0;
        end else begin
            m_up <= 1'b1;
            if (!m_active && m_up && i_req_valid) begin
                m_active <= 1'b1;
                m_n      <= cyc;
                m_req    <= i_req;
                m_data   <= data_cfg;
                if (wait_cfg >= 0 && wait_cfg < T) begin
                    m_len <= wait_cfg + 1;
                    m_to  <= 1'b0;
                end else begin
                    m_len <= T;
                    m_to  <= 1'b1;
                end
            end else if (m_active && cyc >= m_n + 2 + m_len && i_resp_ready) begin
                m_active <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic e_ps, e_pe, e_rv;
        if (!rst_n) begin
            chk("rst_psel", o_apb_m_psel, 0);
            chk("rst_penable", o_apb_m_penable, 0);
            chk("rst_resp_valid", o_resp_valid, 0);
            chk("rst_resp", o_resp, 0);
            chk("rst_timeout", o_resp_timeout, 0);
            chk("rst_apb_req", o_apb_m_req, 0);
            chk("rst_req_ready", o_req_ready, 0);
            chk("rst_busy", o_busy, 0);
        end else begin
            e_ps = m_active && cyc >= m_n + 1 && cyc <= m_n + 1 + m_len;
            e_pe = m_active && cyc >= m_n + 2 && cyc <= m_n + 1 + m_len;
            e_rv = m_active && cyc >= m_n + 2 + m_len;
            chk("psel", o_apb_m_psel, e_ps);
            chk("penable", o_apb_m_penable, e_pe);
            chk("resp_valid", o_resp_valid, e_rv);
            chk("busy", o_busy, m_active);
            chk("req_ready", o_req_ready, m_up && !m_active);
            if (e_ps) chk("apb_req", o_apb_m_req, m_req);
            if (e_rv) begin
                chk("resp", o_resp, m_to ? 32'h0 : m_data);
                chk("resp_timeout", o_resp_timeout, m_to);
            end
        end
    end

    task automatic txn(input logic [63:0] rq, input logic [31:0] d, input int w, input int hold,
                       output logic [31:0] r, output logic to, output int ps, output int pe,
                       output int lat);
        int i;
        @(negedge clk);
        wait_cfg = w; data_cfg = d; i_req = rq; i_req_valid = 1'b1;
        i_resp_ready = (hold == 0);
        ps = 0; pe = 0; lat = 0; i = 0;
        while (!o_req_ready && i < 20) begin @(negedge clk); i++; end
        chk("accept_wait", o_req_ready, 1);
        @(posedge clk); #1 i_req_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            ps += int'(o_apb_m_psel);
            pe += int'(o_apb_m_penable);
        end while (!o_resp_valid && lat < 40);
        chk("resp_wait", o_resp_valid, 1);
        r = o_resp; to = o_resp_timeout;
        if (hold > 0) begin
            i_req = ~rq; i_req_valid = 1'b1;
            repeat (hold) @(negedge clk);
            i_resp_ready = 1'b1; i_req_valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] r;
        logic        to;
        int          ps, pe, lat, na, nr, i;
        logic [31:0] got [3];

        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk("ready_before_edge", o_req_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_edge", o_req_ready, 1);

        // zero-wait slave: N+1 psel, N+2 penable, N+3 response
        txn(64'h0000_1000_DEAD_BEEF, 32'hCAFE_F00D, 0, 0, r, to, ps, pe, lat);
        chk("zw_resp", r, 32'hCAFE_F00D);
        chk("zw_to", to, 0);
        chk("zw_lat", lat, 3);
        chk("zw_psel_cycles", ps, 2);
        chk("zw_pen_cycles", pe, 1);

        txn(64'h0000_2000_1234_5678, 32'h1111_2222, 5, 0, r, to, ps, pe, lat);
        chk("w5_resp", r, 32'h1111_2222);
        chk("w5_pen_cycles", pe, 6);
        chk("w5_psel_cycles", ps, 7);

        txn(64'h0000_3000_0000_0001, 32'h3333_4444, -1, 0, r, to, ps, pe, lat);
        chk("to_resp", r, 32'h0);
        chk("to_flag", to, 1);
        chk("to_pen_cycles", pe, 8);
        chk("to_psel_cycles", ps, 9);

        // pready on the very cycle the timeout would fire: normal response
        txn(64'h0000_4000_0000_0002, 32'h5555_6666, 7, 0, r, to, ps, pe, lat);
        chk("tie_resp", r, 32'h5555_6666);
        chk("tie_flag", to, 0);
        txn(64'h0000_4000_0000_0003, 32'h7777_8888, 8, 0, r, to, ps, pe, lat);
        chk("late_flag", to, 1);
        chk("late_pen_cycles", pe, 8);

        // consumer stalls 10 cycles with a competing request pending
        txn(64'h0000_5000_0000_0004, 32'h9999_AAAA, 2, 10, r, to, ps, pe, lat);
        chk("hold_resp", r, 32'h9999_AAAA);
        chk("hold_lat", lat, 5);

        // reset in the middle of ACCESS
        @(negedge clk);
        wait_cfg = -1; data_cfg = 32'hBAD0_BAD0; i_req = 64'h0000_6000_0000_0005;
        i_req_valid = 1'b1; i_resp_ready = 1'b1; i = 0;
        while (!o_req_ready && i < 20) begin @(negedge clk); i++; end
        @(posedge clk); #1 i_req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("mid_penable", o_apb_m_penable, 1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("abort_psel", o_apb_m_psel, 0);
        chk("abort_penable", o_apb_m_penable, 0);
        chk("abort_resp_valid", o_resp_valid, 0);
        chk("abort_busy", o_busy, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        txn(64'h0000_7000_0000_0006, 32'h0BAD_CAFE, 1, 0, r, to, ps, pe, lat);
        chk("post_rst_resp", r, 32'h0BAD_CAFE);
        chk("post_rst_lat", lat, 4);

        // back-to-back with valid held high
        @(negedge clk);
        wait_cfg = 0; i_resp_ready = 1'b1; i_req_valid = 1'b1; na = 0; nr = 0;
        for (int c = 0; c < 16; c++) begin
            if (o_resp_valid && nr < 3) begin got[nr] = o_resp; nr++; end
            if (o_req_ready) begin
                if (na < 3) begin
                    i_req = 64'h100 + 64'(na); data_cfg = 32'hB000 + 32'(na); na++;
                end else i_req_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_count", nr, 3);
        for (int k = 0; k < 3; k++) chk("b2b_order", got[k], 32'hB000 + 32'(k));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/multisim_server_apb_pull.md
MULTISIM_SERVER_APB_PULL -- requirements
Module: multisim_server_apb_pull

Interface
REQ-001 SHALL have parameter apb_req_t, default logic [63:0], opaque APB request (address/write/wdata) driven unchanged onto the bus.
REQ-002 SHALL have parameter apb_resp_t, default logic [31:0], opaque APB response captured from the slave.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, max ACCESS-phase cycles waiting for pready; 0 disables timeout.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_req_valid  input  1  pulled request available.
REQ-007 SHALL have port o_req_ready  output  1  request accepted when high with i_req_valid.
REQ-008 SHALL have port i_req  input  apb_req_t  pulled request payload.
REQ-009 SHALL have port o_resp_valid  output  1  completed response available.
REQ-010 SHALL have port i_resp_ready  input  1  consumer takes response.
REQ-011 SHALL have port o_resp  output  apb_resp_t  captured response.
REQ-012 SHALL have port o_resp_timeout  output  1  response produced by timeout, o_resp is zero.
REQ-013 SHALL have port o_apb_m_req  output  apb_req_t  APB master request.
REQ-014 SHALL have port i_apb_m_resp  input  apb_resp_t  APB slave response.
REQ-015 SHALL have port o_apb_m_psel  output  1  APB select.
REQ-016 SHALL have port o_apb_m_penable  output  1  APB enable.
REQ-017 SHALL have port i_apb_m_pready  input  1  APB slave ready.
REQ-018 SHALL have port o_busy  output  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; one transaction in flight.
REQ-020 IDLE: o_req_ready=1; on i_req_valid&&o_req_ready latch i_req into o_apb_m_req, go SETUP next cycle.
REQ-021 SETUP: psel=1, penable=0, exactly one cycle, then ACCESS.
REQ-022 ACCESS: psel=1, penable=1; o_apb_m_req held stable; timeout counter increments each cycle pready is low.
REQ-023 ACCESS with pready=1: capture i_apb_m_resp into o_resp, o_resp_timeout=0, go RESP; psel/penable low next cycle.
REQ-024 ACCESS with counter reaching TIMEOUT_CYCLES (and TIMEOUT_CYCLES!=0) and pready low: o_resp=0, o_resp_timeout=1, drop psel/penable, go RESP.
REQ-025 pready and timeout in same cycle: pready wins, normal response.
REQ-026 RESP: o_resp_valid=1, o_resp/o_resp_timeout stable until i_resp_ready; on handshake go IDLE, o_resp_valid low next cycle.
REQ-027 o_req_ready SHALL be 0 outside IDLE; i_req ignored while busy.
REQ-028 Minimum transaction latency: accept at cycle N, psel at N+1, penable at N+2, o_resp_valid at N+3 with zero-wait slave.
REQ-029 Timeout counter 32-bit, cleared on entering SETUP; SHALL never wrap within one transaction.
REQ-030 pready outside ACCESS SHALL be ignored.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, psel=0, penable=0, o_apb_m_req=0, o_resp=0, o_resp_valid=0, o_resp_timeout=0, counter=0, o_busy=0.
REQ-032 o_req_ready SHALL be 0 while rst_n low, 1 from first clock edge after deassertion.
REQ-033 Reset mid-ACCESS SHALL abort transaction with no response produced; pending response in RESP discarded.

Verification
REQ-034 Zero-wait slave, req=0x0000_1000_DEAD_BEEF, resp_ready=1 -> psel at N+1, penable at N+2, o_resp_valid at N+3, o_resp = slave data 0xCAFE_F00D, timeout=0.
REQ-035 Slave pready after 5 wait cycles -> penable high 6 cycles, o_apb_m_req stable throughout, one response.
REQ-036 TIMEOUT_CYCLES=8, pready never high -> psel drops after 8 ACCESS cycles, o_resp=0, o_resp_timeout=1.
REQ-037 i_resp_ready low 10 cycles in RESP -> o_resp_valid held, o_req_ready=0, new i_req_valid not accepted until handshake.
REQ-038 rst_n asserted in ACCESS -> psel/penable low immediately, no o_resp_valid, next request after reset runs normally.
REQ-039 Back-to-back requests with i_req_valid held high -> each transaction separated by one IDLE cycle, responses in order.
